// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles.
// Define CLK_PERIOD_METER_DUTY_EN to build the fall path and high_time output.
module clk_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_MAX = 1000000,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 sig_in,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int W1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] TMAX = CNT_WIDTH'(TIMEOUT_MAX);
  localparam logic [MW-1:0]        LCNT = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TMO
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_prev;
  logic [CNT_WIDTH-1:0]   r_period;
  logic [MW-1:0]          r_match;
  logic                   r_seeded;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_tmo;

  logic [W1-1:0]          w_a;
  logic [W1-1:0]          w_b;
  logic [W1-1:0]          w_diff;
  logic [MW-1:0]          w_match_nxt;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  assign w_a    = {1'b0, r_cnt};
  assign w_b    = {1'b0, r_prev};
  assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

  // the seeding measurement never scores a match
  always_comb begin
    w_match_nxt = '0;
    if (r_seeded && (w_diff <= W1'(LOCK_TOL))) begin
      if (r_match == LCNT)
        w_match_nxt = r_match;
      else
        w_match_nxt = r_match + MW'(1);
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic                 w_fall;
  logic [CNT_WIDTH-1:0] r_hlatch;
  logic [CNT_WIDTH-1:0] r_high;

  assign w_fall = ~w_s & r_s_d;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_hlatch <= '0;
      r_high   <= '0;
    end else if (clr) begin
      r_hlatch <= '0;
      r_high   <= '0;
    end else if (w_rise) begin
      r_hlatch <= '0;
      if (r_state == MEASURE)
        r_high <= (r_hlatch != '0) ? r_hlatch : r_cnt;
    end else if (r_state == MEASURE && w_fall) begin
      r_hlatch <= r_cnt;
    end
  end

  assign high_time = r_high;
`else
  assign high_time = '0;
`endif

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_prev   <= '0;
      r_period <= '0;
      r_match  <= '0;
      r_seeded <= 1'b0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clr) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_period <= '0;
        r_match  <= '0;
        r_seeded <= 1'b0;
        r_locked <= 1'b0;
        r_tmo    <= 1'b0;
      end else if (w_rise) begin
        r_cnt <= CNT_WIDTH'(1);
        if (r_state == MEASURE) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
          r_prev   <= r_cnt;
          r_seeded <= 1'b1;
          r_match  <= w_match_nxt;
          r_locked <= (w_match_nxt == LCNT);
        end else begin
          r_state  <= MEASURE;
          r_tmo    <= 1'b0;
          r_seeded <= 1'b0;
          r_match  <= '0;
        end
      end else begin
        if (r_cnt != TMAX)
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (r_state != TMO && r_cnt == TMAX) begin
          r_state  <= TMO;
          r_tmo    <= 1'b1;
          r_locked <= 1'b0;
          r_match  <= '0;
        end
      end
    end
  end

  assign period     = r_period;
  assign meas_valid = r_valid;
  assign locked     = r_locked;
  assign timeout    = r_tmo;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: timestamp/queue model checked every cycle,
// two DUTs (LOCK_TOL 2 and 1) sharing one stimulus, plus literal spot checks.
module tb_clk_period_meter;

  localparam int S  = 2;
  localparam int TM = 50;
  localparam int LC = 4;
`ifdef CLK_PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rstn   = 1'b0;
  logic        sig_in = 1'b0;
  logic        clr    = 1'b0;
  logic [31:0] period, high_time, period1, high1;
  logic        mv, lk, to, mv1, lk1, to1;

  always #5 clk_in = ~clk_in;

  clk_period_meter #(.SYNC_STAGES(S), .CNT_WIDTH(32), .TIMEOUT_MAX(TM),
                     .LOCK_TOL(2), .LOCK_COUNT(LC)) dut (
    .clk_in(clk_in), .rstn(rstn), .sig_in(sig_in), .clr(clr),
    .period(period), .high_time(high_time), .meas_valid(mv),
    .locked(lk), .timeout(to));

  clk_period_meter #(.SYNC_STAGES(S), .CNT_WIDTH(32), .TIMEOUT_MAX(TM),
                     .LOCK_TOL(1), .LOCK_COUNT(LC)) dut1 (
    .clk_in(clk_in), .rstn(rstn), .sig_in(sig_in), .clr(clr),
    .period(period1), .high_time(high1), .meas_valid(mv1),
    .locked(lk1), .timeout(to1));

  int pass_n = 0;
  int chk_n  = 0;

  task automatic chk(string nm, longint act, longint exp);
    chk_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // model: pin history indexed by edge number, rise timestamps, period queue
  bit     hist[0:8191];
  int     cyc = 0, floor_c = 0, ref_c = 0, mode = 0, e = 0;
  bit     pend = 1'b1, r_ev, f_ev;
  longint m_period = 0, m_high = 0, fallv = 0;
  bit     m_valid = 0, m_lk2 = 0, m_lk1 = 0, m_tmo = 0;
  int     q[$];

  function automatic bit hv(int i);
    if (i < 0 || i < floor_c || i > 8191) return 1'b0;
    return hist[i];
  endfunction

  function automatic bit lockchk(int tol);
    int n, d;
    n = q.size();
    if (n < LC + 1) return 1'b0;
    for (int i = n - LC; i < n; i++) begin
      d = q[i] - q[i-1];
      if (d < 0) d = -d;
      if (d > tol) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pend = 1'b1; mode = 0; fallv = 0; q.delete();
      m_period = 0; m_high = 0; m_valid = 0;
      m_lk2 = 0; m_lk1 = 0; m_tmo = 0;
    end else begin
      cyc++;
      if (cyc <= 8191) hist[cyc] = sig_in;
      if (pend) begin floor_c = cyc; ref_c = cyc; pend = 1'b0; end
      e = cyc - ref_c;
      if (e > TM) e = TM;
      r_ev = hv(cyc - S) & ~hv(cyc - S - 1);
      f_ev = ~hv(cyc - S) & hv(cyc - S - 1);
      m_valid = 1'b0;
      if (clr) begin
        mode = 0; ref_c = cyc + 1; fallv = 0; q.delete();
        m_period = 0; m_high = 0; m_lk2 = 0; m_lk1 = 0; m_tmo = 0;
      end else if (r_ev) begin
        if (mode == 1) begin
          m_period = e;
          m_high   = DUTY ? ((fallv != 0) ? fallv : e) : 0;
          m_valid  = 1'b1;
          q.push_back(e);
          m_lk2 = lockchk(2);
          m_lk1 = lockchk(1);
        end else begin
          mode = 1; m_tmo = 0; q.delete();
        end
        fallv = 0;
        ref_c = cyc;
      end else if (mode != 2 && e == TM) begin
        mode = 2; m_tmo = 1; m_lk2 = 0; m_lk1 = 0; q.delete();
      end else if (mode == 1 && f_ev) begin
        fallv = e;
      end
    end
  end

  int nneg = 0, n_valid = 0, last_mv = 0, to_rise = 0;
  bit to_prev = 0, lk1_seen = 0;

  always @(negedge clk_in) begin
    nneg++;
    if (rstn) begin
      chk("period", period, m_period);
      chk("high_time", high_time, m_high);
      chk("meas_valid", mv, m_valid);
      chk("locked", lk, m_lk2);
      chk("timeout", to, m_tmo);
      chk("period_tol1", period1, m_period);
      chk("high_tol1", high1, m_high);
      chk("valid_tol1", mv1, m_valid);
      chk("locked_tol1", lk1, m_lk1);
      chk("timeout_tol1", to1, m_tmo);
      if (mv) begin n_valid++; last_mv = nneg; end
      if (to && !to_prev) to_rise = nneg;
      if (lk1) lk1_seen = 1'b1;
    end
    to_prev = to;
  end

  task automatic cyc_n(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic sq(int hi, int lo, int n);
    repeat (n) begin
      sig_in = 1'b1; cyc_n(hi);
      sig_in = 1'b0; cyc_n(lo);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc_n(1); clr = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_period", period, 0);
    chk("rst_valid", mv, 0);
    chk("rst_locked", lk, 0);
    chk("rst_timeout", to, 0);
    cyc_n(2); rstn = 1'b1; cyc_n(3);

    // 10-cycle period, 5 high
    n_valid = 0;
    sq(5, 5, 5);
    chk("s1_valid_cnt5", n_valid, 4);
    chk("s1_period", period, 10);
    chk("s1_high", high_time, DUTY ? 5 : 0);
    chk("s1_unlocked5", lk, 0);
    sq(5, 5, 3);
    chk("s1_locked", lk, 1);
    chk("s1_valid_cnt8", n_valid, 7);

    // one 14-cycle period breaks lock
    sq(7, 7, 1);
    sq(5, 5, 1);
    chk("s2_period14", period, 14);
    chk("s2_high7", high_time, DUTY ? 7 : 0);
    chk("s2_dropped", lk, 0);
    sq(5, 5, 5);
    chk("s2_relocked", lk, 1);

    // 10/12 jitter from a cleared start
    pulse_clr();
    cyc_n(1);
    chk("s3_clr_period", period, 0);
    lk1_seen = 1'b0;
    repeat (6) begin sq(5, 5, 1); sq(6, 6, 1); end
    chk("s3_lock_tol2", lk, 1);
    chk("s3_never_tol1", lk1_seen, 0);

    // timeout after lock, then restart
    sq(5, 5, 4);
    cyc_n(60);
    chk("s4_timeout", to, 1);
    chk("s4_unlocked", lk, 0);
    chk("s4_period_held", period, 10);
    chk("s4_to_delay", to_rise - last_mv, 50);
    n_valid = 0;
    sq(5, 5, 3);
    chk("s4_to_cleared", to, 0);
    chk("s4_restart_valid", n_valid, 2);

    // clr coincident with a detected rise while locked
    sq(5, 5, 6);
    chk("s5_locked", lk, 1);
    n_valid = 0;
    sig_in = 1'b1; cyc_n(2);
    clr = 1'b1; cyc_n(1); clr = 1'b0;
    chk("s5_clr_locked", lk, 0);
    chk("s5_clr_period", period, 0);
    chk("s5_clr_valid", n_valid, 0);
    cyc_n(3); sig_in = 1'b0; cyc_n(5);

    // async reset mid-measurement
    sq(5, 5, 3);
    sig_in = 1'b1; cyc_n(3); sig_in = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("s6_rst_period", period, 0);
    chk("s6_rst_high", high_time, 0);
    chk("s6_rst_locked", lk, 0);
    chk("s6_rst_valid", mv, 0);
    cyc_n(2); rstn = 1'b1; cyc_n(2);
    n_valid = 0;
    sq(5, 5, 2);
    chk("s6_valid_cnt", n_valid, 1);
    chk("s6_period", period, 10);
    chk("s6_high", high_time, DUTY ? 5 : 0);
    chk("s6_unlocked", lk, 0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
